i2c_cmd_sequencer: RTL
======================

Name: i2c_cmd_sequencer

Overview:
- Transaction-level controller between the APB register file and the byte-level I2C engine.
- Accepts one command: direction, 7-bit target address and byte count.
- Sequences the engine through START, address, N data bytes and STOP, one operation at a time.
- Drains the transmit FIFO on writes, fills the receive FIFO on reads, and reports busy/NACK/timeout status for the status register.

Parameters:
TIMEOUT, 4096, PCLK cycles allowed between an engine op strobe and eng_done before abort
CW, 13, width of timeout counter (must hold TIMEOUT)

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  single-cycle command request
cmd_rw  in  1  1=read, 0=write
cmd_addr  in  7  target address
cmd_len  in  4  byte count 0..15
tx_empty  in  1  transmit FIFO empty
tx_data  in  8  transmit FIFO head
tx_rd  out  1  pop transmit FIFO (one cycle)
rx_full  in  1  receive FIFO full
rx_data  out  8  byte to push
rx_wr  out  1  push receive FIFO (one cycle)
eng_start  out  1  strobe: generate START
eng_stop  out  1  strobe: generate STOP
eng_write  out  1  strobe: shift out eng_din
eng_read  out  1  strobe: shift in one byte
eng_ack_out  out  1  ACK bit for read (1=NACK), valid with eng_read
eng_din  out  8  byte to send, valid with eng_write
eng_dout  in  8  received byte, valid with eng_done after read
eng_ack_in  in  1  slave ACK after write (1=NACK), valid with eng_done
eng_done  in  1  single-cycle op completion
eng_abort  out  1  one-cycle engine reset on timeout
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at transaction end
nack_err  out  1  sticky: address or data NACKed
timeout_err  out  1  sticky: engine timeout

Behaviour:
- Reset: all outputs 0, eng_din/rx_data 0, state IDLE, counters 0.
- States: IDLE, START, ADDR, WAIT_TX, WRITE, READ, WAIT_RX, STOP.
- Each op state asserts exactly one strobe for one cycle on entry, then waits for eng_done. Strobes are never issued while an op is outstanding.
- IDLE: cmd_valid latches rw/addr/len, clears nack_err and timeout_err, sets busy. eng_start is asserted in the next cycle. cmd_valid while busy is ignored, with no side effects.
- START done -> ADDR. ADDR issues eng_write with eng_din={cmd_addr,cmd_rw}.
- ADDR done:
  - eng_ack_in=1 -> set nack_err, go to STOP.
  - else len=0 -> STOP (address probe).
  - else rw=0 -> WAIT_TX.
  - else -> READ.
- WAIT_TX:
  - Stalls while tx_empty=1, with no timeout.
  - When not empty: tx_rd pulses, eng_din=tx_data, eng_write asserted in the same cycle -> WRITE.
- WRITE done:
  - NACK -> nack_err, go to STOP.
  - else decrement remaining; remaining=0 -> STOP, else WAIT_TX.
- READ: eng_read with eng_ack_out=1 only for the last byte (remaining=1), otherwise 0.
- READ done:
  - rx_full=0: rx_data=eng_dout and rx_wr pulse on the next cycle.
  - rx_full=1: hold in WAIT_RX with rx_data latched until space, then rx_wr.
  - After the push, decrement remaining; 0 -> STOP, else READ.
- STOP done: done pulse, busy=0, return to IDLE in the same cycle. A new cmd_valid is accepted from the following cycle.
- Latency: eng_done in cycle M -> next strobe in cycle M+1 (except stalls in WAIT_TX/WAIT_RX).
- Timeout:
  - Counter clears on each strobe and counts while waiting for eng_done.
  - Reaching TIMEOUT: eng_abort pulse, timeout_err set, done pulse, busy=0, go to IDLE. No STOP is issued.
- eng_done arriving in IDLE, WAIT_TX or WAIT_RX is ignored.
- Asynchronous reset mid-transaction: immediate return to IDLE with all strobes low. The FIFOs are not popped further.

Test Plan:
- Write, addr=0x50, len=2, FIFO holds 0xA5,0x3C, engine ACKs all:
  - Required sequence: eng_start; eng_write 0xA0; eng_write 0xA5; eng_write 0x3C; eng_stop.
  - Required result: two tx_rd pulses, done pulse, nack_err=0.
- Read, addr=0x21, len=3, engine returns 0x11,0x22,0x33:
  - eng_din=0x43.
  - eng_ack_out sequence 0,0,1.
  - rx_wr pushes 0x11,0x22,0x33, then STOP, then done.
- Address NACK on write, len=4:
  - Sequence: START, ADDR, STOP.
  - Required result: no tx_rd, nack_err=1, done pulse.
  - nack_err clears on the next accepted command.
- Write, len=3, tx_empty held 1 for 20 cycles before byte 2:
  - No strobe during the stall; transaction completes normally.
- Read, len=2, rx_full=1 for 10 cycles after byte 1:
  - rx_wr is withheld, then pushed with the correct data.
  - Second eng_read is issued only after that push.
- Timeouts, probes and ignored commands:
  - TIMEOUT=16, engine never answers eng_start: eng_abort and timeout_err at cycle 16, busy=0.
  - len=0 probe: START/ADDR/STOP only.
  - cmd_valid while busy: ignored.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Transaction sequencer between the APB register file and the byte-level I2C engine.
// Runs START, address, N data bytes and STOP, one engine op at a time, with timeout abort.
module i2c_cmd_sequencer #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CW      = 13
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [3:0] cmd_len,
  input  logic       tx_empty,
  input  logic [7:0] tx_data,
  output logic       tx_rd,
  input  logic       rx_full,
  output logic [7:0] rx_data,
  output logic       rx_wr,
  output logic       eng_start,
  output logic       eng_stop,
  output logic       eng_write,
  output logic       eng_read,
  output logic       eng_ack_out,
  output logic [7:0] eng_din,
  input  logic [7:0] eng_dout,
  input  logic       eng_ack_in,
  input  logic       eng_done,
  output logic       eng_abort,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_WAIT_TX,
    S_WRITE,
    S_READ,
    S_WAIT_RX,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic            issued_q, issued_d;
  logic            rw_q;
  logic [3:0]      rem_q;
  logic [7:0]      din_q;
  logic [7:0]      rx_data_q;
  logic            rx_wr_q;
  logic [CW-1:0]   cnt_q;
  logic            nack_q;
  logic            tout_q;

  logic            latch_cmd;
  logic            load_din;
  logic            dec_rem;
  logic            capture_rx;
  logic            rx_wr_set;
  logic            push_now;
  logic            set_nack;
  logic            abort_txn;
  logic            strobe;
  logic            waiting;
  logic            tout_hit;

  // An op is outstanding once its strobe has been issued and until eng_done.
  assign waiting  = issued_q && !eng_done;
  assign tout_hit = waiting && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    latch_cmd   = 1'b0;
    load_din    = 1'b0;
    dec_rem     = 1'b0;
    capture_rx  = 1'b0;
    rx_wr_set   = 1'b0;
    push_now    = 1'b0;
    set_nack    = 1'b0;
    abort_txn   = 1'b0;
    tx_rd       = 1'b0;
    eng_start   = 1'b0;
    eng_stop    = 1'b0;
    eng_write   = 1'b0;
    eng_read    = 1'b0;
    eng_ack_out = 1'b0;
    eng_din     = din_q;
    eng_abort   = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          latch_cmd = 1'b1;
          issued_d  = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (!issued_q) begin
          eng_start = 1'b1;
          issued_d  = 1'b1;
        end else if (eng_done) begin
          issued_d = 1'b0;
          state_d  = S_ADDR;
        end else if (tout_hit) begin
          abort_txn = 1'b1;
        end
      end
      S_ADDR: begin
        if (!issued_q) begin
          eng_write = 1'b1;
          issued_d  = 1'b1;
        end else if (eng_done) begin
          issued_d = 1'b0;
          if (eng_ack_in) begin
            set_nack = 1'b1;
            state_d  = S_STOP;
          end else if (rem_q == 4'd0) begin
            state_d = S_STOP;
          end else if (!rw_q) begin
            state_d = S_WAIT_TX;
          end else begin
            state_d = S_READ;
          end
        end else if (tout_hit) begin
          abort_txn = 1'b1;
        end
      end
      S_WAIT_TX: begin
        // Pop and write share one cycle, so WRITE is entered with its strobe already issued.
        if (!tx_empty) begin
          tx_rd     = 1'b1;
          eng_write = 1'b1;
          eng_din   = tx_data;
          load_din  = 1'b1;
          issued_d  = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (eng_done) begin
          issued_d = 1'b0;
          if (eng_ack_in) begin
            set_nack = 1'b1;
            state_d  = S_STOP;
          end else begin
            dec_rem = 1'b1;
            state_d = (rem_q == 4'd1) ? S_STOP : S_WAIT_TX;
          end
        end else if (tout_hit) begin
          abort_txn = 1'b1;
        end
      end
      S_READ: begin
        if (!issued_q) begin
          eng_read    = 1'b1;
          eng_ack_out = (rem_q == 4'd1);
          issued_d    = 1'b1;
        end else if (eng_done) begin
          issued_d   = 1'b0;
          capture_rx = 1'b1;
          if (rx_full) begin
            state_d = S_WAIT_RX;
          end else begin
            rx_wr_set = 1'b1;
            dec_rem   = 1'b1;
            state_d   = (rem_q == 4'd1) ? S_STOP : S_READ;
          end
        end else if (tout_hit) begin
          abort_txn = 1'b1;
        end
      end
      S_WAIT_RX: begin
        if (!rx_full) begin
          push_now = 1'b1;
          dec_rem  = 1'b1;
          state_d  = (rem_q == 4'd1) ? S_STOP : S_READ;
        end
      end
      S_STOP: begin
        if (!issued_q) begin
          eng_stop = 1'b1;
          issued_d = 1'b1;
        end else if (eng_done) begin
          done     = 1'b1;
          issued_d = 1'b0;
          state_d  = S_IDLE;
        end else if (tout_hit) begin
          abort_txn = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        issued_d = 1'b0;
      end
    endcase

    if (abort_txn) begin
      eng_abort = 1'b1;
      done      = 1'b1;
      issued_d  = 1'b0;
      state_d   = S_IDLE;
    end

    strobe = eng_start | eng_stop | eng_write | eng_read;
    busy   = (state_q != S_IDLE) && !done;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      issued_q  <= 1'b0;
      rw_q      <= 1'b0;
      rem_q     <= '0;
      din_q     <= '0;
      rx_data_q <= '0;
      rx_wr_q   <= 1'b0;
      cnt_q     <= '0;
      nack_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      rx_wr_q  <= rx_wr_set;

      if (latch_cmd) begin
        rw_q   <= cmd_rw;
        rem_q  <= cmd_len;
        din_q  <= {cmd_addr, cmd_rw};
        nack_q <= 1'b0;
        tout_q <= 1'b0;
      end else begin
        if (dec_rem) rem_q <= rem_q - 4'd1;
        if (load_din) din_q <= tx_data;
        if (set_nack) nack_q <= 1'b1;
        if (abort_txn) tout_q <= 1'b1;
      end

      if (capture_rx) rx_data_q <= eng_dout;

      if (strobe) begin
        cnt_q <= '0;
      end else if (waiting) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_wr       = rx_wr_q | push_now;
  assign nack_err    = nack_q;
  assign timeout_err = tout_q;

endmodule
